// File: rtl/circuit1_window_acc.sv
// Window accumulator for the circuit1 datapath: saturating sum of x and signed max of z
// over WIN accepted samples, presented on a valid/ready result port.
module circuit1_window_acc #(
  parameter int XW   = 16,
  parameter int ZW   = 8,
  parameter int ACCW = 24,
  parameter int WIN  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [XW-1:0]   x,
  input  logic signed [ZW-1:0]   z,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [ACCW-1:0] out_sum,
  output logic signed [ZW-1:0]   out_max,
  output logic                   out_ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam int CW = (WIN > 1) ? $clog2(WIN) : 1;

  state_t                 r_state;
  logic [CW-1:0]          r_count;
  logic signed [ACCW-1:0] r_acc;
  logic signed [ZW-1:0]   r_max;
  logic                   r_ovf;
  logic                   r_out_valid;
  logic signed [ACCW-1:0] r_out_sum;
  logic signed [ZW-1:0]   r_out_max;
  logic                   r_out_ovf;

  logic                   w_accept;
  logic                   w_take;
  logic                   w_last;
  logic signed [ACCW-1:0] w_x_ext;
  logic signed [ACCW:0]   w_sum_wide;
  logic signed [ACCW-1:0] w_acc_next;
  logic signed [ZW-1:0]   w_max_next;
  logic                   w_ovf_next;

  // One guard bit is enough: the top two bits of the widened sum disagree only on overflow.
  function automatic logic sat_hit(input logic signed [ACCW:0] s);
    return s[ACCW] != s[ACCW-1];
  endfunction

  function automatic logic signed [ACCW-1:0] sat_clamp(input logic signed [ACCW:0] s);
    if (s[ACCW] == s[ACCW-1])
      return s[ACCW-1:0];
    else if (s[ACCW])
      return {1'b1, {(ACCW-1){1'b0}}};
    else
      return {1'b0, {(ACCW-1){1'b1}}};
  endfunction

  function automatic logic signed [ZW-1:0] smax(input logic signed [ZW-1:0] a,
                                                input logic signed [ZW-1:0] b);
    return (b > a) ? b : a;
  endfunction

  assign in_ready   = !flush && ((r_state != HOLD) || out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_take     = r_out_valid && out_ready;
  assign w_last     = (r_count == CW'(WIN - 1));

  assign w_x_ext    = ACCW'(x);
  assign w_sum_wide = (ACCW+1)'(r_acc) + (ACCW+1)'(w_x_ext);
  assign w_acc_next = sat_clamp(w_sum_wide);
  assign w_ovf_next = r_ovf | sat_hit(w_sum_wide);
  assign w_max_next = smax(r_max, z);

  assign out_valid  = r_out_valid;
  assign out_sum    = r_out_sum;
  assign out_max    = r_out_max;
  assign out_ovf    = r_out_ovf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_acc       <= '0;
      r_max       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_max   <= '0;
      r_out_ovf   <= 1'b0;
    end else if (flush) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_acc <= w_x_ext;
            r_max <= z;
            r_ovf <= 1'b0;
            if (WIN == 1) begin
              r_out_sum   <= w_x_ext;
              r_out_max   <= z;
              r_out_ovf   <= 1'b0;
              r_out_valid <= 1'b1;
              r_count     <= '0;
              r_state     <= HOLD;
            end else begin
              r_count <= CW'(1);
              r_state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_acc <= w_acc_next;
            r_max <= w_max_next;
            r_ovf <= w_ovf_next;
            if (w_last) begin
              r_out_sum   <= w_acc_next;
              r_out_max   <= w_max_next;
              r_out_ovf   <= w_ovf_next;
              r_out_valid <= 1'b1;
              r_count     <= '0;
              r_state     <= HOLD;
            end else begin
              r_count <= r_count + CW'(1);
            end
          end
        end
        HOLD: begin
          if (w_take) begin
            if (w_accept) begin
              // Result leaves and the next window's first sample arrives in the same cycle.
              r_acc <= w_x_ext;
              r_max <= z;
              r_ovf <= 1'b0;
              if (WIN == 1) begin
                r_out_sum   <= w_x_ext;
                r_out_max   <= z;
                r_out_ovf   <= 1'b0;
                r_out_valid <= 1'b1;
                r_state     <= HOLD;
              end else begin
                r_count     <= CW'(1);
                r_out_valid <= 1'b0;
                r_state     <= ACCUM;
              end
            end else begin
              r_out_valid <= 1'b0;
              r_state     <= IDLE;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_count     <= '0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
